// File: rtl/ysyx_25040111_mem_arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states, owner tags,
// access-size codes and the latched request record.
package ysyx_25040111_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        ERR  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam logic [1:0] MASK_B = 2'b01;
    localparam logic [1:0] MASK_H = 2'b10;
    localparam logic [1:0] MASK_W = 2'b11;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  mask;
        logic        rsign;
    } mem_req_t;

    // Halves need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [1:0] mask, input logic [1:0] offset);
        return ((mask == MASK_H) && offset[0]) || ((mask == MASK_W) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/ysyx_25040111_mem_arb_if.sv
// Single-port memory bus between the arbiter (master) and the memory (slave).
interface ysyx_25040111_mem_arb_if;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req_valid, mem_write, mem_addr, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_write, mem_addr, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );

endinterface

// File: rtl/ysyx_25040111_lsu_align.sv
// Byte-lane handling for the shared port: store strobes and lane replication,
// load shift and sign/zero extension. Purely combinational.
module ysyx_25040111_lsu_align
    import ysyx_25040111_mem_arb_pkg::*;
(
    input  logic        write,
    input  logic [1:0]  mask,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic        rsign,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [3:0]  strb_base;
    logic [31:0] shifted;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        strb_base  = 4'b1111;
        wdata_lane = wdata;
        shifted    = rdata_raw >> {offset, 3'b000};
        rdata_ext  = shifted;
        unique case (mask)
            MASK_B: begin
                strb_base  = 4'b0001;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{rsign & shifted[7]}}, shifted[7:0]};
            end
            MASK_H: begin
                strb_base  = 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{rsign & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
        wstrb = write ? (strb_base << offset) : 4'b0000;
    end

endmodule

// File: rtl/ysyx_25040111_mem_arb.sv
// Two-requester arbiter for the core memory port (IFU fetch vs. LSU access),
// one transaction outstanding, registered completion pulses.
module ysyx_25040111_mem_arb
    import ysyx_25040111_mem_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b1,
    parameter int RD_W  = 5
) (
    input  logic            clock,
    input  logic            reset,

    input  logic            ifu_valid,
    output logic            ifu_ready,
    input  logic [31:0]     ifu_addr,
    output logic            ifu_rvalid,
    output logic [31:0]     ifu_rdata,

    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic            lsu_write,
    input  logic [31:0]     lsu_addr,
    input  logic [31:0]     lsu_wdata,
    input  logic [1:0]      lsu_mask,
    input  logic            lsu_rsign,
    input  logic [RD_W-1:0] lsu_rd,
    output logic            lsu_finish,
    output logic [RD_W-1:0] lsu_frd,
    output logic [31:0]     lsu_rdata,
    output logic            lsu_err,

    ysyx_25040111_mem_arb_if.master bus
);

    arb_state_e      state_q, state_d;
    owner_e          last_grant_q, last_grant_d;
    owner_e          owner_q, owner_d;
    mem_req_t        req_q, req_d;
    logic [RD_W-1:0] req_rd_q, req_rd_d;

    logic            ifu_rvalid_q, ifu_rvalid_d;
    logic [31:0]     ifu_rdata_q, ifu_rdata_d;
    logic            lsu_finish_q, lsu_finish_d;
    logic            lsu_err_q, lsu_err_d;
    logic [RD_W-1:0] lsu_frd_q, lsu_frd_d;
    logic [31:0]     lsu_rdata_q, lsu_rdata_d;

    logic            grant_lsu;
    logic [31:0]     ld_data;

    ysyx_25040111_lsu_align u_align (
        .write      (req_q.write),
        .mask       (req_q.mask),
        .offset     (req_q.addr[1:0]),
        .wdata      (req_q.wdata),
        .rsign      (req_q.rsign),
        .rdata_raw  (bus.mem_rdata),
        .wstrb      (bus.mem_wstrb),
        .wdata_lane (bus.mem_wdata),
        .rdata_ext  (ld_data)
    );

    assign bus.mem_req_valid = (state_q == REQ);
    assign bus.mem_write     = req_q.write;
    assign bus.mem_addr      = {req_q.addr[31:2], 2'b00};

    assign ifu_rvalid = ifu_rvalid_q;
    assign ifu_rdata  = ifu_rdata_q;
    assign lsu_finish = lsu_finish_q;
    assign lsu_err    = lsu_err_q;
    assign lsu_frd    = lsu_frd_q;
    assign lsu_rdata  = lsu_rdata_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        req_d        = req_q;
        req_rd_d     = req_rd_q;
        ifu_rvalid_d = 1'b0;
        ifu_rdata_d  = ifu_rdata_q;
        lsu_finish_d = 1'b0;
        lsu_err_d    = 1'b0;
        lsu_frd_d    = lsu_frd_q;
        lsu_rdata_d  = lsu_rdata_q;

        // On conflict the LSU wins unless it was the last one served under round-robin.
        grant_lsu = lsu_valid & (~ifu_valid | ~RR_EN | (last_grant_q == OWN_IFU));
        ifu_ready = (state_q == IDLE) & ifu_valid & ~grant_lsu;
        lsu_ready = (state_q == IDLE) & lsu_valid &  grant_lsu;

        unique case (state_q)
            IDLE: begin
                if (lsu_ready) begin
                    req_d        = '{write: lsu_write, addr: lsu_addr, wdata: lsu_wdata,
                                     mask: lsu_mask, rsign: lsu_rsign};
                    req_rd_d     = lsu_rd;
                    owner_d      = OWN_LSU;
                    last_grant_d = OWN_LSU;
                    if (is_misaligned(lsu_mask, lsu_addr[1:0])) begin
                        state_d      = ERR;
                        lsu_finish_d = 1'b1;
                        lsu_err_d    = 1'b1;
                        lsu_frd_d    = lsu_rd;
                        lsu_rdata_d  = '0;
                    end else begin
                        state_d = REQ;
                    end
                end else if (ifu_ready) begin
                    req_d        = '{write: 1'b0, addr: ifu_addr, wdata: '0,
                                     mask: MASK_W, rsign: 1'b0};
                    owner_d      = OWN_IFU;
                    last_grant_d = OWN_IFU;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (bus.mem_req_ready) state_d = RSP;
            end
            RSP: begin
                if (bus.mem_rsp_valid) begin
                    state_d = IDLE;
                    if (owner_q == OWN_IFU) begin
                        ifu_rvalid_d = 1'b1;
                        ifu_rdata_d  = bus.mem_rdata;
                    end else begin
                        lsu_finish_d = 1'b1;
                        lsu_frd_d    = req_rd_q;
                        lsu_rdata_d  = req_q.write ? 32'h0 : ld_data;
                    end
                end
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: request and data registers are reset too, so every output reads 0 out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= OWN_IFU;
            owner_q      <= OWN_IFU;
            req_q        <= '0;
            req_rd_q     <= '0;
            ifu_rvalid_q <= 1'b0;
            ifu_rdata_q  <= '0;
            lsu_finish_q <= 1'b0;
            lsu_err_q    <= 1'b0;
            lsu_frd_q    <= '0;
            lsu_rdata_q  <= '0;
        end else begin
            // NOTE: non-blocking updates keep every flop sampling pre-edge values.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            req_q        <= req_d;
            req_rd_q     <= req_rd_d;
            ifu_rvalid_q <= ifu_rvalid_d;
            ifu_rdata_q  <= ifu_rdata_d;
            lsu_finish_q <= lsu_finish_d;
            lsu_err_q    <= lsu_err_d;
            lsu_frd_q    <= lsu_frd_d;
            lsu_rdata_q  <= lsu_rdata_d;
        end
    end

endmodule

// File: tb/tb_ysyx_25040111_mem_arb.sv
// Directed bench for the memory arbiter: a round-robin instance and a
// fixed-priority instance share the requester stimulus.
module tb_ysyx_25040111_mem_arb;

    logic        clock;
    logic        reset;
    logic        ifu_valid;
    logic [31:0] ifu_addr;
    logic        lsu_valid;
    logic        lsu_write;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [1:0]  lsu_mask;
    logic        lsu_rsign;
    logic [4:0]  lsu_rd;

    logic        ifu_ready, ifu_rvalid, lsu_ready, lsu_finish, lsu_err;
    logic [31:0] ifu_rdata, lsu_rdata;
    logic [4:0]  lsu_frd;

    logic        fp_ifu_ready, fp_ifu_rvalid, fp_lsu_ready, fp_lsu_finish, fp_lsu_err;
    logic [31:0] fp_ifu_rdata, fp_lsu_rdata;
    logic [4:0]  fp_lsu_frd;

    int vectors     = 0;
    int miscompares = 0;

    ysyx_25040111_mem_arb_if bus ();
    ysyx_25040111_mem_arb_if bus_fp ();

    assign bus_fp.mem_req_ready = bus.mem_req_ready;
    assign bus_fp.mem_rsp_valid = bus.mem_rsp_valid;
    assign bus_fp.mem_rdata     = bus.mem_rdata;

    ysyx_25040111_mem_arb #(.RR_EN(1'b1), .RD_W(5)) dut (
        .clock(clock), .reset(reset),
        .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .ifu_addr(ifu_addr),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_write(lsu_write),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_mask(lsu_mask),
        .lsu_rsign(lsu_rsign), .lsu_rd(lsu_rd), .lsu_finish(lsu_finish),
        .lsu_frd(lsu_frd), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .bus(bus)
    );

    ysyx_25040111_mem_arb #(.RR_EN(1'b0), .RD_W(5)) dut_fp (
        .clock(clock), .reset(reset),
        .ifu_valid(ifu_valid), .ifu_ready(fp_ifu_ready), .ifu_addr(ifu_addr),
        .ifu_rvalid(fp_ifu_rvalid), .ifu_rdata(fp_ifu_rdata),
        .lsu_valid(lsu_valid), .lsu_ready(fp_lsu_ready), .lsu_write(lsu_write),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_mask(lsu_mask),
        .lsu_rsign(lsu_rsign), .lsu_rd(lsu_rd), .lsu_finish(fp_lsu_finish),
        .lsu_frd(fp_lsu_frd), .lsu_rdata(fp_lsu_rdata), .lsu_err(fp_lsu_err),
        .bus(bus_fp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Full LSU transaction with immediate bus ready and response; returns in the completion cycle.
    task automatic run_lsu(input string tag, input logic w, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] mask, input logic rsign,
                           input logic [4:0] rd, input logic [31:0] rsp_data,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_rdata);
        lsu_valid = 1'b1; lsu_write = w; lsu_addr = addr; lsu_wdata = wdata;
        lsu_mask = mask; lsu_rsign = rsign; lsu_rd = rd;
        #1;
        check1($sformatf("%s lsu_ready", tag), lsu_ready, 1'b1);
        check1($sformatf("%s ifu_ready", tag), ifu_ready, 1'b0);
        cyc();
        lsu_valid = 1'b0;
        check1($sformatf("%s req_valid", tag), bus.mem_req_valid, 1'b1);
        check32($sformatf("%s mem_addr", tag), bus.mem_addr, {addr[31:2], 2'b00});
        check1($sformatf("%s mem_write", tag), bus.mem_write, w);
        check32($sformatf("%s mem_wstrb", tag), 32'(bus.mem_wstrb), 32'(exp_strb));
        check32($sformatf("%s mem_wdata", tag), bus.mem_wdata, exp_wdata);
        bus.mem_req_ready = 1'b1;
        cyc();
        bus.mem_req_ready = 1'b0;
        check1($sformatf("%s req_dropped", tag), bus.mem_req_valid, 1'b0);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = rsp_data;
        cyc();
        bus.mem_rsp_valid = 1'b0;
        check1($sformatf("%s finish", tag), lsu_finish, 1'b1);
        check1($sformatf("%s err", tag), lsu_err, 1'b0);
        check32($sformatf("%s rdata", tag), lsu_rdata, exp_rdata);
        check32($sformatf("%s frd", tag), 32'(lsu_frd), 32'(rd));
    endtask

    task automatic run_err(input string tag, input logic [31:0] addr, input logic [1:0] mask,
                           input logic [4:0] rd);
        lsu_valid = 1'b1; lsu_write = 1'b0; lsu_addr = addr; lsu_wdata = 32'h0;
        lsu_mask = mask; lsu_rsign = 1'b0; lsu_rd = rd;
        #1;
        check1($sformatf("%s lsu_ready", tag), lsu_ready, 1'b1);
        cyc();
        lsu_valid = 1'b0;
        check1($sformatf("%s no_req", tag), bus.mem_req_valid, 1'b0);
        check1($sformatf("%s finish", tag), lsu_finish, 1'b1);
        check1($sformatf("%s err", tag), lsu_err, 1'b1);
        check32($sformatf("%s rdata", tag), lsu_rdata, 32'h0);
        check32($sformatf("%s frd", tag), 32'(lsu_frd), 32'(rd));
        cyc();
        check1($sformatf("%s finish_end", tag), lsu_finish, 1'b0);
        check1($sformatf("%s err_end", tag), lsu_err, 1'b0);
        check1($sformatf("%s no_req_end", tag), bus.mem_req_valid, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        ifu_valid = 1'b0; ifu_addr = 32'h0;
        lsu_valid = 1'b0; lsu_write = 1'b0; lsu_addr = 32'h0; lsu_wdata = 32'h0;
        lsu_mask = 2'b11; lsu_rsign = 1'b0; lsu_rd = 5'd0;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rdata = 32'h0;

        // Reset state
        cyc(); cyc();
        check1("rst ifu_ready", ifu_ready, 1'b0);
        check1("rst lsu_ready", lsu_ready, 1'b0);
        check1("rst ifu_rvalid", ifu_rvalid, 1'b0);
        check1("rst lsu_finish", lsu_finish, 1'b0);
        check1("rst lsu_err", lsu_err, 1'b0);
        check1("rst req_valid", bus.mem_req_valid, 1'b0);
        check32("rst mem_addr", bus.mem_addr, 32'h0);
        check32("rst mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
        check32("rst lsu_rdata", lsu_rdata, 32'h0);
        check32("rst ifu_rdata", ifu_rdata, 32'h0);
        reset = 1'b0;
        cyc();

        // Lone fetch: accept T, request T+1, response T+2, pulse T+3
        ifu_valid = 1'b1; ifu_addr = 32'h8000_0000;
        #1;
        check1("f1 ifu_ready", ifu_ready, 1'b1);
        check1("f1 lsu_ready", lsu_ready, 1'b0);
        cyc();
        ifu_valid = 1'b0;
        check1("f1 req_valid", bus.mem_req_valid, 1'b1);
        check32("f1 mem_addr", bus.mem_addr, 32'h8000_0000);
        check1("f1 mem_write", bus.mem_write, 1'b0);
        check32("f1 mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
        check1("f1 ready_busy", ifu_ready, 1'b0);
        bus.mem_req_ready = 1'b1;
        cyc();
        bus.mem_req_ready = 1'b0;
        check1("f1 req_dropped", bus.mem_req_valid, 1'b0);
        check1("f1 no_early_rvalid", ifu_rvalid, 1'b0);
        bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'h0010_0073;
        cyc();
        bus.mem_rsp_valid = 1'b0;
        check1("f1 rvalid", ifu_rvalid, 1'b1);
        check32("f1 rdata", ifu_rdata, 32'h0010_0073);
        check1("f1 no_lsu_finish", lsu_finish, 1'b0);
        cyc();
        check1("f1 rvalid_end", ifu_rvalid, 1'b0);
        check32("f1 rdata_hold", ifu_rdata, 32'h0010_0073);

        // Conflict: both held, bus always ready and responding
        bus.mem_req_ready = 1'b1; bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'hCAFE_0001;
        ifu_valid = 1'b1; ifu_addr = 32'h8000_0008;
        lsu_valid = 1'b1; lsu_write = 1'b0; lsu_addr = 32'h8000_0010; lsu_wdata = 32'h0;
        lsu_mask = 2'b11; lsu_rsign = 1'b0; lsu_rd = 5'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            check1($sformatf("rr%0d lsu_ready", i), lsu_ready, (i % 2) == 0);
            check1($sformatf("rr%0d ifu_ready", i), ifu_ready, (i % 2) == 1);
            check1($sformatf("fp%0d lsu_ready", i), fp_lsu_ready, 1'b1);
            check1($sformatf("fp%0d ifu_ready", i), fp_ifu_ready, 1'b0);
            cyc();
            check1($sformatf("rr%0d no_ready_busy", i), ifu_ready | lsu_ready, 1'b0);
            cyc(); cyc();
        end
        ifu_valid = 1'b0; lsu_valid = 1'b0;
        check1("rr last ifu_rvalid", ifu_rvalid, 1'b1);
        check32("rr last ifu_rdata", ifu_rdata, 32'hCAFE_0001);
        check1("fp last lsu_finish", fp_lsu_finish, 1'b1);
        check32("fp last lsu_rdata", fp_lsu_rdata, 32'hCAFE_0001);
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
        cyc();

        // Loads: lane shift and extension
        run_lsu("lb_s", 1'b0, 32'h8000_0003, 32'h0, 2'b01, 1'b1, 5'd5, 32'h80FF_FFFF,
                4'b0000, 32'h0, 32'hFFFF_FF80);
        cyc();
        check1("lb_s finish_end", lsu_finish, 1'b0);
        check32("lb_s rdata_hold", lsu_rdata, 32'hFFFF_FF80);
        run_lsu("lb_u", 1'b0, 32'h8000_0003, 32'h0, 2'b01, 1'b0, 5'd6, 32'h80FF_FFFF,
                4'b0000, 32'h0, 32'h0000_0080);
        run_lsu("lh_s", 1'b0, 32'h8000_0002, 32'h0, 2'b10, 1'b1, 5'd1, 32'h8001_1234,
                4'b0000, 32'h0, 32'hFFFF_8001);
        run_lsu("lw", 1'b0, 32'h8000_0004, 32'h0, 2'b11, 1'b1, 5'd8, 32'h1234_5678,
                4'b0000, 32'h0, 32'h1234_5678);

        // Stores: strobes and lane replication
        run_lsu("sh", 1'b1, 32'h8000_0002, 32'h0000_BEEF, 2'b10, 1'b0, 5'd7, 32'hFFFF_FFFF,
                4'b1100, 32'hBEEF_BEEF, 32'h0);
        run_lsu("sb", 1'b1, 32'h8000_0001, 32'h1234_56A5, 2'b01, 1'b0, 5'd10, 32'hFFFF_FFFF,
                4'b0010, 32'hA5A5_A5A5, 32'h0);
        run_lsu("sw", 1'b1, 32'h8000_0008, 32'hDEAD_BEEF, 2'b11, 1'b0, 5'd11, 32'hFFFF_FFFF,
                4'b1111, 32'hDEAD_BEEF, 32'h0);
        cyc();

        // Misaligned accesses
        run_err("lw_mis", 32'h8000_0002, 2'b11, 5'd9);
        run_err("lh_mis", 32'h8000_0031, 2'b10, 5'd12);

        // Bus stall: request held stable for 5 cycles
        lsu_valid = 1'b1; lsu_write = 1'b1; lsu_addr = 32'h8000_0021; lsu_wdata = 32'h0000_005A;
        lsu_mask = 2'b01; lsu_rsign = 1'b0; lsu_rd = 5'd3;
        #1;
        check1("stall lsu_ready", lsu_ready, 1'b1);
        cyc();
        lsu_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check1($sformatf("stall%0d req_valid", i), bus.mem_req_valid, 1'b1);
            check32($sformatf("stall%0d mem_addr", i), bus.mem_addr, 32'h8000_0020);
            check32($sformatf("stall%0d mem_wdata", i), bus.mem_wdata, 32'h5A5A_5A5A);
            check32($sformatf("stall%0d mem_wstrb", i), 32'(bus.mem_wstrb), 32'h2);
            cyc();
        end
        bus.mem_req_ready = 1'b1;
        cyc();
        bus.mem_req_ready = 1'b0;

        // Reset while waiting for the response, then a stale response
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        check1("rrst req_valid", bus.mem_req_valid, 1'b0);
        cyc();
        bus.mem_rsp_valid = 1'b0;
        check1("rrst lsu_finish", lsu_finish, 1'b0);
        check1("rrst ifu_rvalid", ifu_rvalid, 1'b0);
        check1("rrst lsu_err", lsu_err, 1'b0);
        check32("rrst lsu_rdata", lsu_rdata, 32'h0);
        check32("rrst lsu_frd", 32'(lsu_frd), 32'h0);
        check32("rrst ifu_rdata", ifu_rdata, 32'h0);
        check32("rrst mem_addr", bus.mem_addr, 32'h0);
        check32("rrst mem_wdata", bus.mem_wdata, 32'h0);
        check32("rrst mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
        cyc();
        check1("rrst finish_late", lsu_finish, 1'b0);
        check1("rrst req_late", bus.mem_req_valid, 1'b0);

        // FSM is idle: a new fetch is accepted at once and completes normally
        ifu_valid = 1'b1; ifu_addr = 32'h8000_0004;
        #1;
        check1("f2 ifu_ready", ifu_ready, 1'b1);
        cyc();
        ifu_valid = 1'b0;
        check32("f2 mem_addr", bus.mem_addr, 32'h8000_0004);
        bus.mem_req_ready = 1'b1;
        cyc();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'h0000_0013;
        cyc();
        bus.mem_rsp_valid = 1'b0;
        check1("f2 rvalid", ifu_rvalid, 1'b1);
        check32("f2 rdata", ifu_rdata, 32'h0000_0013);
        cyc();
        check1("f2 rvalid_end", ifu_rvalid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
